// File: rtl/z80_sram_dma_ctrl.sv
// rtl/z80_sram_dma_ctrl.sv - Z80 bus-request arbiter and SRAM transfer controller
// Requests the Z80 bus, then runs single-byte SRAM reads/writes with registered strobes.
module z80_sram_dma_ctrl #(
    parameter int STROBE_CYC = 2,
    parameter int GRANT_TMO  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busack_n,
    output logic        busrq_n,
    input  logic        host_sess,
    output logic        host_owned,
    output logic        host_err,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [13:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        cmd_done,
    output logic [7:0]  cmd_rdata,
    output logic [13:0] ma,
    output logic [7:0]  md_out,
    output logic        md_oe,
    input  logic [7:0]  md_in,
    output logic        mce,
    output logic        moe,
    output logic        mwe,
    output logic        cpu_lsoe
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        OWN,
        SETUP,
        STRB,
        DONE,
        REL
    } state_t;

    localparam logic [8:0] TMO_LIMIT  = 9'(GRANT_TMO);
    localparam logic [3:0] STRB_LAST  = 4'(STROBE_CYC - 1);

    state_t      state_q, state_d;
    logic        busack_meta_q, busack_s_q;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  strb_cnt_q, strb_cnt_d;
    logic [13:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        host_err_q, host_err_d;

    logic        busrq_n_q, busrq_n_d;
    logic        cpu_lsoe_q, cpu_lsoe_d;
    logic        mce_q, mce_d;
    logic        moe_q, moe_d;
    logic        mwe_q, mwe_d;
    logic        md_oe_q, md_oe_d;
    logic        owned_q, owned_d;
    logic        done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            busack_meta_q <= 1'b1;
            busack_s_q    <= 1'b1;
        end else begin
            busack_meta_q <= busack_n;
            busack_s_q    <= busack_meta_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        strb_cnt_d = '0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        rdata_d    = rdata_q;
        host_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (host_sess) state_d = REQ;
            end
            REQ: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (!host_sess) begin
                    state_d = REL;
                end else if (!busack_s_q) begin
                    state_d = OWN;
                end else if ({1'b0, wait_cnt_q} + 9'd1 >= TMO_LIMIT) begin
                    host_err_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            OWN: begin
                // A pending command wins over a session drop in the same cycle.
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wr_d    = cmd_wr;
                    state_d = SETUP;
                end else if (!host_sess) begin
                    state_d = REL;
                end
            end
            SETUP: begin
                state_d = STRB;
            end
            STRB: begin
                if (strb_cnt_q == STRB_LAST) begin
                    if (!wr_q) rdata_d = md_in;
                    state_d = DONE;
                end else begin
                    strb_cnt_d = strb_cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = OWN;
            end
            REL: begin
                if (busack_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered so SRAM strobes never glitch.
        busrq_n_d  = !(state_d inside {REQ, OWN, SETUP, STRB, DONE});
        cpu_lsoe_d = (state_d inside {IDLE, REQ});
        mce_d      = !(state_d inside {SETUP, STRB, DONE});
        moe_d      = !((state_d == STRB) && !wr_d);
        mwe_d      = !((state_d == STRB) && wr_d);
        md_oe_d    = (state_d inside {SETUP, STRB, DONE}) && wr_d;
        owned_d    = (state_d == OWN);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            strb_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            rdata_q    <= '0;
            host_err_q <= 1'b0;
            busrq_n_q  <= 1'b1;
            cpu_lsoe_q <= 1'b1;
            mce_q      <= 1'b1;
            moe_q      <= 1'b1;
            mwe_q      <= 1'b1;
            md_oe_q    <= 1'b0;
            owned_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            strb_cnt_q <= strb_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rdata_q    <= rdata_d;
            host_err_q <= host_err_d;
            busrq_n_q  <= busrq_n_d;
            cpu_lsoe_q <= cpu_lsoe_d;
            mce_q      <= mce_d;
            moe_q      <= moe_d;
            mwe_q      <= mwe_d;
            md_oe_q    <= md_oe_d;
            owned_q    <= owned_d;
            done_q     <= done_d;
        end
    end

    assign busrq_n    = busrq_n_q;
    assign cpu_lsoe   = cpu_lsoe_q;
    assign host_owned = owned_q;
    assign cmd_ready  = owned_q;
    assign host_err   = host_err_q;
    assign cmd_done   = done_q;
    assign cmd_rdata  = rdata_q;
    assign ma         = addr_q;
    assign md_out     = wdata_q;
    assign md_oe      = md_oe_q;
    assign mce        = mce_q;
    assign moe        = moe_q;
    assign mwe        = mwe_q;

endmodule

// File: doc/z80_sram_dma_ctrl.md
Z80_SRAM_DMA_CTRL -- requirements
Module: z80_sram_dma_ctrl

Interface
REQ-001 Parameter STROBE_CYC, default 2: cycles moe/mwe held low per transfer, legal 1..15.
REQ-002 Parameter GRANT_TMO, default 255: max cycles waiting for bus grant, legal 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 busack_n  input  1  Z80 BUSACK, active low, asynchronous to clk.
REQ-006 busrq_n  output  1  Z80 BUSRQ, active low.
REQ-007 host_sess  input  1  host wants to own the SRAM bus while high.
REQ-008 host_owned  output  1  high while the controller owns the bus and accepts commands.
REQ-009 host_err  output  1  one-cycle pulse on grant timeout.
REQ-010 cmd_valid  input  1  command request, sampled only when cmd_ready=1.
REQ-011 cmd_ready  output  1  high only in state OWN.
REQ-012 cmd_wr  input  1  1=write, 0=read.
REQ-013 cmd_addr  input  14  SRAM address (16 KB window).
REQ-014 cmd_wdata  input  8  write data.
REQ-015 cmd_done  output  1  one-cycle pulse at transfer completion.
REQ-016 cmd_rdata  output  8  read data, valid from cmd_done until next read completes.
REQ-017 ma  output  14  SRAM address; md_out  output  8  SRAM write data; md_oe  output  1  data-bus drive enable; md_in  input  8  SRAM read data.
REQ-018 mce, moe, mwe  output  1 each  SRAM chip select, output enable, write enable, all active low.
REQ-019 cpu_lsoe  output  1  CPU-side level-shifter enable; low = Hi-z.

Function
REQ-020 busack_n SHALL pass through a 2-flop synchronizer (busack_s) before use; flops reset to 1.
REQ-021 States SHALL be IDLE, REQ, OWN, SETUP, STRB, DONE, REL.
REQ-022 IDLE: busrq_n=1, cpu_lsoe=1, mce=moe=mwe=1, md_oe=0; host_sess=1 -> REQ.
REQ-023 REQ: busrq_n=0; 8-bit wait counter increments each cycle; busack_s=0 -> OWN; counter reaching GRANT_TMO with no grant -> host_err pulse, busrq_n=1, -> IDLE.
REQ-024 host_sess=0 in REQ SHALL go to REL.
REQ-025 OWN: busrq_n=0, cpu_lsoe=0, host_owned=1, cmd_ready=1; cmd_valid=1 -> latch cmd_addr/cmd_wdata/cmd_wr -> SETUP; else host_sess=0 -> REL; cmd_valid takes priority over session drop.
REQ-026 SETUP (1 cycle): mce=0, ma=latched addr, md_oe=latched wr, moe=mwe=1.
REQ-027 STRB (STROBE_CYC cycles): mce=0; read: moe=0; write: mwe=0, md_oe=1; on last STRB cycle a read SHALL latch md_in into cmd_rdata.
REQ-028 DONE (1 cycle): mce=0, moe=mwe=1, md_oe held for writes (data hold), cmd_done=1 -> OWN.
REQ-029 A started transfer SHALL always complete; host_sess dropping during SETUP/STRB/DONE is acted on in OWN.
REQ-030 REL: busrq_n=1, cpu_lsoe=0, SRAM strobes inactive; busack_s=1 -> IDLE (cpu_lsoe=1 from IDLE).
REQ-031 moe and mwe SHALL never be low in the same cycle; md_oe SHALL never be 1 when moe=0.
REQ-032 ma, md_out SHALL be stable from SETUP through DONE.
REQ-033 Transfer latency: cmd_valid accepted in cycle N -> cmd_done in cycle N+STROBE_CYC+2.

Reset
REQ-034 reset=1 SHALL force IDLE in the next cycle from any state, including mid-transfer: busrq_n=1, cpu_lsoe=1, mce=moe=mwe=1, md_oe=0, host_owned=0, cmd_ready=0, cmd_done=0, host_err=0, cmd_rdata=0, ma=0, md_out=0, wait counter=0.

Verification
REQ-035 host_sess=1, busack_n low 3 cycles after busrq_n falls -> host_owned=1 two sync cycles later, cpu_lsoe=0.
REQ-036 In OWN, write addr 0x1234 data 0xA5, STROBE_CYC=2 -> SETUP, mwe=0 for exactly 2 cycles, md_out=0xA5, cmd_done at N+4; then read 0x1234 -> cmd_rdata=0xA5.
REQ-037 busack_n held high, GRANT_TMO=10 -> host_err pulse after 10 REQ cycles, busrq_n returns 1, state IDLE.
REQ-038 host_sess dropped during STRB -> transfer completes, cmd_done pulses, then REL, busrq_n=1, IDLE after busack_n rises.
REQ-039 reset asserted during STRB of a write -> next cycle mwe=1, mce=1, busrq_n=1, md_oe=0.
REQ-040 Every cycle of all scenarios: assertions of REQ-031 hold.
